// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants: next-PC source encoding,
// fetch FSM states, the sequential PC step, and a low-bit mask helper.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_BR,
        PC_J,
        PC_JR
    } pc_sel_t;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD_REDIR
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Mask covering the low address bits that must be zero for an aligned fetch.
    function automatic logic [31:0] low_mask(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select: jr > jump > branch_taken > sequential.
// Purely combinational; also reports which source won.
module pc_next_mux
    import mips_pkg::*;
(
    input  logic [31:0] i_pc_plus4,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    input  logic        i_jr,
    input  logic [31:0] i_jr_target,
    output logic [31:0] o_target,
    output pc_sel_t     o_sel
);

    // Fixed-priority pick of the redirect source, falling back to pc+4.
    always_comb begin
        o_target = i_pc_plus4;
        o_sel    = PC_SEQ;
        if (i_jr) begin
            o_target = i_jr_target;
            o_sel    = PC_JR;
        end else if (i_jump) begin
            o_target = i_jump_target;
            o_sel    = PC_J;
        end else if (i_branch_taken) begin
            o_target = i_branch_target;
            o_sel    = PC_BR;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF-stage program counter: pc register, next-PC selection, stall handling,
// redirect capture while stalled, and one-slot squash after every redirect.
// Optional feature macro: PC_ALIGN_CHECK_EN (forces target low bits to zero and
// raises a sticky misaligned flag); when undefined targets load unmodified.
module pc_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        redirect_pending,
    output logic        misaligned
);

    localparam logic [31:0] LOW_MASK = low_mask(ALIGN_BITS);
    // RESET_PC is required to be aligned; masking keeps a bad override harmless.
    localparam logic [31:0] BOOT_PC  = RESET_PC & ~LOW_MASK;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic         r_if_valid;
    logic         w_if_valid_nxt;
    logic [31:0]  r_pend_pc;
    logic         w_pend_cap;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic [31:0]  w_load_target;
    pc_sel_t      w_sel;
    logic         w_redirect;

    assign w_pc_plus4 = r_pc + PC_STEP;

    pc_next_mux u_next_mux (
        .i_pc_plus4      (w_pc_plus4),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_jr            (jr),
        .i_jr_target     (jr_target),
        .o_target        (w_target),
        .o_sel           (w_sel)
    );

    assign w_redirect = (w_sel != PC_SEQ);

`ifdef PC_ALIGN_CHECK_EN
    logic r_misaligned;
    logic w_take;

    // A redirect is accepted (applied or captured) only while running.
    assign w_take        = (r_state == RUN) && w_redirect;
    assign w_load_target = w_target & ~LOW_MASK;

    // Sticky flag: any accepted target with nonzero low bits latches until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (w_take && (|(w_target & LOW_MASK))) begin
            r_misaligned <= 1'b1;
        end
    end

    assign misaligned = r_misaligned;
`else
    assign w_load_target = w_target;
    assign misaligned    = 1'b0;
`endif

    // FSM state, pc and slot-valid flag; reset restarts fetch from BOOT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= BOOT;
            r_pc       <= BOOT_PC;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    // Captured redirect target; only meaningful while in HOLD_REDIR.
    always_ff @(posedge clk) begin
        if (w_pend_cap) begin
            r_pend_pc <= w_load_target;
        end
    end

    // Next-state, next-pc and squash decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_pend_cap     = 1'b0;
        case (r_state)
            BOOT: begin
                // Redirects are ignored; first real fetch at BOOT_PC follows.
                w_state_nxt    = RUN;
                w_if_valid_nxt = 1'b1;
            end
            RUN: begin
                if (!stall) begin
                    if (w_redirect) begin
                        w_pc_nxt       = w_load_target;
                        w_if_valid_nxt = 1'b0;
                    end else begin
                        w_pc_nxt       = w_pc_plus4;
                        w_if_valid_nxt = 1'b1;
                    end
                end else if (w_redirect) begin
                    // Remember the redirect; pc and valid hold during the stall.
                    w_pend_cap  = 1'b1;
                    w_state_nxt = HOLD_REDIR;
                end
            end
            HOLD_REDIR: begin
                // First captured target wins; new redirects are ignored here.
                if (!stall) begin
                    w_pc_nxt       = r_pend_pc;
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = RUN;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    assign pc               = r_pc;
    assign pc_plus4         = w_pc_plus4;
    assign if_valid         = r_if_valid;
    assign redirect_pending = (r_state == HOLD_REDIR);

endmodule
